// File: rtl/cpu_cfg_mailbox_pkg.sv
// Shared definitions for the CPU-side config mailbox: register indexes,
// status-register bit positions and the default command timeout.
package cpu_cfg_mailbox_pkg;

  typedef enum logic [2:0] {
    SR      = 3'd0,
    CMD     = 3'd1,
    DATA0   = 3'd2,
    DATA1   = 3'd3,
    DONE    = 3'd4,
    IRQ_CLR = 3'd5
  } e_cpu_cfg_reg;

  localparam int SR_READY       = 0;
  localparam int SR_BUSY        = 1;
  localparam int SR_USB_WAITING = 2;
  localparam int SR_CMD_ERROR   = 3;
  localparam int SR_IRQ         = 4;
  localparam int SR_OVERRUN     = 5;
  localparam int SR_TIMEOUT     = 8;

  localparam logic [23:0] TIMEOUT_CYCLES_DEFAULT = 24'd16_000_000;

endpackage

// File: rtl/cpu_cfg_timeout.sv
// Busy-time counter for the config mailbox; expire is high during the last
// permitted busy cycle so the owner can force completion on that edge.
module cpu_cfg_timeout #(
  parameter int         W     = 24,
  parameter logic [W-1:0] LIMIT = W'(16_000_000)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] LAST = LIMIT - {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en && (count_q == LAST);

endmodule

// File: rtl/cpu_cfg_mailbox.sv
// CPU-side mailbox for N64 config commands: latches commands, raises an IRQ
// and exposes a register window. Optional busy timeout: SC64_CFG_TIMEOUT_EN.
module cpu_cfg_mailbox
  import cpu_cfg_mailbox_pkg::*;
#(
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(TIMEOUT_CYCLES_DEFAULT)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [2:0]  cpu_address,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_irq,
  input  logic        cfg_cmd_request,
  input  logic [7:0]  cfg_cmd,
  input  logic [31:0] cfg_data0,
  input  logic [31:0] cfg_data1,
  output logic        cfg_cpu_ready,
  output logic        cfg_cpu_busy,
  output logic        cfg_usb_waiting,
  output logic        cfg_cmd_error,
  output logic [1:0]  cfg_data_write,
  output logic [31:0] cfg_wdata
);

  typedef enum logic {S_IDLE, S_BUSY} e_state;

  e_state      state_q, state_d;
  logic        ack_q, ack_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        usb_q, usb_d;
  logic        err_q, err_d;
  logic        irq_q, irq_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  dw_q, dw_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr, done_wr, accept, timeout_fire;
  logic [31:0] sr;

`ifdef SC64_CFG_TIMEOUT_EN
  cpu_cfg_timeout #(
    .W     (TIMEOUT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     (state_q == S_BUSY),
    .expire (timeout_fire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, accept};
  assign timeout_fire       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    usb_d     = usb_q;
    err_d     = err_q;
    irq_d     = irq_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    dw_d      = 2'b00;
    wdata_d   = wdata_q;
    ack_d     = cpu_req;
    addr_d    = cpu_req ? cpu_address : addr_q;
    accept    = 1'b0;
    wr        = cpu_req && cpu_write;
    done_wr   = wr && (cpu_address == DONE) && (state_q == S_BUSY);

    if (wr) begin
      case (cpu_address)
        SR: begin
          ready_d = cpu_wdata[SR_READY];
          usb_d   = cpu_wdata[SR_USB_WAITING];
        end
        DATA0: begin
          wdata_d = cpu_wdata;
          dw_d    = 2'b01;
        end
        DATA1: begin
          wdata_d = cpu_wdata;
          dw_d    = 2'b10;
        end
        IRQ_CLR: irq_d = 1'b0;
        default: ;
      endcase
    end

    // DONE outranks an expiring timeout in the same cycle
    if (done_wr) begin
      busy_d    = 1'b0;
      err_d     = cpu_wdata[0];
      irq_d     = 1'b0;
      overrun_d = 1'b0;
      state_d   = S_IDLE;
    end else if (timeout_fire) begin
      busy_d    = 1'b0;
      err_d     = 1'b1;
      timeout_d = 1'b1;
      irq_d     = 1'b0;
      state_d   = S_IDLE;
    end

    // A completion in the same cycle frees the slot for the new command
    if (cfg_cmd_request) begin
      if ((state_q == S_IDLE) || done_wr) begin
        accept = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (accept) begin
      cmd_d     = cfg_cmd;
      busy_d    = 1'b1;
      err_d     = 1'b0;
      irq_d     = 1'b1;
      timeout_d = 1'b0;
      state_d   = S_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      addr_q    <= 3'd0;
      cmd_q     <= 8'd0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      usb_q     <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      dw_q      <= 2'b00;
      wdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      usb_q     <= usb_d;
      err_q     <= err_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      dw_q      <= dw_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    sr                 = 32'd0;
    sr[SR_READY]       = ready_q;
    sr[SR_BUSY]        = busy_q;
    sr[SR_USB_WAITING] = usb_q;
    sr[SR_CMD_ERROR]   = err_q;
    sr[SR_IRQ]         = irq_q;
    sr[SR_OVERRUN]     = overrun_q;
    sr[SR_TIMEOUT]     = timeout_q;
  end

  // Read data reflects register contents on the ack cycle only
  always_comb begin
    cpu_rdata = 32'd0;
    if (ack_q) begin
      case (addr_q)
        SR:      cpu_rdata = sr;
        CMD:     cpu_rdata = {24'd0, cmd_q};
        DATA0:   cpu_rdata = cfg_data0;
        DATA1:   cpu_rdata = cfg_data1;
        default: cpu_rdata = 32'd0;
      endcase
    end
  end

  assign cpu_ack         = ack_q;
  assign cpu_irq         = irq_q;
  assign cfg_cpu_ready   = ready_q;
  assign cfg_cpu_busy    = busy_q;
  assign cfg_usb_waiting = usb_q;
  assign cfg_cmd_error   = err_q;
  assign cfg_data_write  = dw_q;
  assign cfg_wdata       = wdata_q;

endmodule

// File: tb/tb_cpu_cfg_mailbox.sv
// Scoreboard bench for cpu_cfg_mailbox; covers both SC64_CFG_TIMEOUT_EN builds.
module tb_cpu_cfg_mailbox;

  localparam logic [23:0] TO = 24'd64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_write = 1'b0;
  logic [2:0]  cpu_address = 3'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_irq;
  logic        cfg_cmd_request = 1'b0;
  logic [7:0]  cfg_cmd = 8'd0;
  logic [31:0] cfg_data0 = 32'h1234_5678;
  logic [31:0] cfg_data1 = 32'hCAFE_F00D;
  logic        cfg_cpu_ready, cfg_cpu_busy, cfg_usb_waiting, cfg_cmd_error;
  logic [1:0]  cfg_data_write;
  logic [31:0] cfg_wdata;

  cpu_cfg_mailbox #(
    .TIMEOUT_W      (24),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_req         (cpu_req),
    .cpu_write       (cpu_write),
    .cpu_address     (cpu_address),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_ack         (cpu_ack),
    .cpu_irq         (cpu_irq),
    .cfg_cmd_request (cfg_cmd_request),
    .cfg_cmd         (cfg_cmd),
    .cfg_data0       (cfg_data0),
    .cfg_data1       (cfg_data1),
    .cfg_cpu_ready   (cfg_cpu_ready),
    .cfg_cpu_busy    (cfg_cpu_busy),
    .cfg_usb_waiting (cfg_usb_waiting),
    .cfg_cmd_error   (cfg_cmd_error),
    .cfg_data_write  (cfg_data_write),
    .cfg_wdata       (cfg_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [31:0] exp;
    string       tag;
  } sb_t;

  sb_t  sb[$];
  sb_t  mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  logic req_seen = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Layout matches SR bits 0..4, with the data write strobe in bits 6:5
  function automatic logic [31:0] flags();
    return {25'd0, cfg_data_write, cpu_irq, cfg_cmd_error, cfg_usb_waiting,
            cfg_cpu_busy, cfg_cpu_ready};
  endfunction

  task automatic cpu_rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    cpu_req     = 1'b1;
    cpu_write   = 1'b0;
    cpu_address = addr;
    sb.push_back('{1'b1, exp, tag});
    @(posedge clk);
    #1 cpu_req = 1'b0;
  endtask

  task automatic cpu_wr(input logic [2:0] addr, input logic [31:0] data);
    cpu_req     = 1'b1;
    cpu_write   = 1'b1;
    cpu_address = addr;
    cpu_wdata   = data;
    sb.push_back('{1'b0, 32'd0, "wr"});
    @(posedge clk);
    #1 cpu_req = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] c);
    cfg_cmd_request = 1'b1;
    cfg_cmd         = c;
    @(posedge clk);
    #1 cfg_cmd_request = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) req_seen <= cpu_req;

  always @(negedge clk) begin
    if (req_seen || cpu_ack) check_val("ack_timing", {31'd0, cpu_ack}, {31'd0, req_seen});
    if (cpu_ack) begin
      if (sb.size() == 0) begin
        check_val("ack_unexp", {31'd0, cpu_ack}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_rd) check_val(mon_e.tag, cpu_rdata, mon_e.exp);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_val("rst_flags", flags(), 32'h0);
    check_val("rst_wdata", cfg_wdata, 32'h0);
    check_val("rst_rdata", cpu_rdata, 32'h0);

    cpu_rd(3'd0, 32'h0, "rd_sr_rst");
    cpu_rd(3'd7, 32'h0, "rd_undef7");
    cpu_wr(3'd6, 32'hFFFF_FFFF);
    check_val("undef_wr_flags", flags(), 32'h0);

    cpu_wr(3'd0, 32'hFFFF_FFFF);
    check_val("sr_wr_flags", flags(), 32'h05);
    cpu_rd(3'd0, 32'h05, "rd_sr_rw");
    cpu_wr(3'd0, 32'h0);
    check_val("sr_clr_flags", flags(), 32'h0);

    cmd(8'h53);
    check_val("cmd53_flags", flags(), 32'h12);
    cpu_rd(3'd1, 32'h53, "rd_cmd53");
    cpu_rd(3'd0, 32'h12, "rd_sr_busy");

    cpu_wr(3'd3, 32'hDEAD_BEEF);
    check_val("data1_strobe", flags(), 32'h52);
    check_val("data1_wdata", cfg_wdata, 32'hDEAD_BEEF);
    tick(1);
    check_val("data1_strobe_end", flags(), 32'h12);
    cpu_wr(3'd2, 32'h0BAD_F00D);
    check_val("data0_strobe", flags(), 32'h32);
    check_val("data0_wdata", cfg_wdata, 32'h0BAD_F00D);
    cpu_rd(3'd2, 32'h1234_5678, "rd_data0");
    cpu_rd(3'd3, 32'hCAFE_F00D, "rd_data1");

    cpu_wr(3'd5, 32'h0);
    check_val("irqclr_flags", flags(), 32'h02);
    cpu_rd(3'd0, 32'h02, "rd_sr_irqclr");

    cmd(8'h11);
    check_val("overrun_flags", flags(), 32'h02);
    cpu_rd(3'd1, 32'h53, "rd_cmd_kept");
    cpu_rd(3'd0, 32'h22, "rd_sr_overrun");

    cpu_wr(3'd4, 32'h1);
    check_val("done_err_flags", flags(), 32'h08);
    cpu_rd(3'd0, 32'h08, "rd_sr_done");

    cmd(8'h44);
    check_val("cmd44_flags", flags(), 32'h12);
    cmd(8'h11);
    cpu_rd(3'd0, 32'h32, "rd_sr_overrun2");
    cfg_cmd_request = 1'b1;
    cfg_cmd         = 8'h22;
    cpu_wr(3'd4, 32'h1);
    cfg_cmd_request = 1'b0;
    check_val("done_req_flags", flags(), 32'h12);
    cpu_rd(3'd1, 32'h22, "rd_cmd22");
    cpu_rd(3'd0, 32'h12, "rd_sr_done_req");

    cpu_wr(3'd4, 32'h0);
    check_val("done_ok_flags", flags(), 32'h0);
    cpu_wr(3'd4, 32'h1);
    check_val("done_idle_flags", flags(), 32'h0);
    cpu_rd(3'd0, 32'h0, "rd_sr_idle");

    cmd(8'h77);
`ifdef SC64_CFG_TIMEOUT_EN
    begin
      int n;
      n = 0;
      for (int i = 1; i <= 200; i++) begin
        @(posedge clk);
        #1;
        if (!cfg_cpu_busy) begin
          n = i;
          break;
        end
      end
      check_val("to_latency", n, {8'd0, TO});
      check_val("to_flags", flags(), 32'h08);
      cpu_rd(3'd0, 32'h108, "rd_sr_timeout");
    end
`else
    tick(1000);
    check_val("no_to_flags", flags(), 32'h12);
    cpu_rd(3'd0, 32'h12, "rd_sr_no_to");
    cpu_wr(3'd4, 32'h0);
    check_val("no_to_done", flags(), 32'h0);
`endif

    cmd(8'h33);
    check_val("cmd33_flags", flags(), 32'h12);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_val("midrst_flags", flags(), 32'h0);
    cpu_rd(3'd1, 32'h0, "rd_cmd_after_rst");
    cpu_rd(3'd0, 32'h0, "rd_sr_after_rst");
    cmd(8'h5A);
    check_val("cmd5a_flags", flags(), 32'h12);
    cpu_rd(3'd1, 32'h5A, "rd_cmd5a");

    tick(3);
    check_val("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
